mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have ports: clk input 1 system clock; rst input 1 asynchronous active-high reset.
REQ-002 SHALL have inputs from the EX/MEM register: mem_mem_to_reg 2, mem_mem_read_en 1, mem_mem_write_en 1, mem_reg_write_en 1, mem_alu_result 32 (address or ALU value), mem_rs2_data 32 (store data), mem_rd_addr 5, mem_funct3 3 (access size/sign).
REQ-003 SHALL have a data-memory bus: dmem_req output 1, dmem_we output 1, dmem_addr output 32 (word-aligned), dmem_wdata output 32, dmem_wstrb output 4, dmem_ack input 1, dmem_rdata input 32.
REQ-004 SHALL have pipeline control: mem_stall output 1; upstream stages hold all inputs while it is high.
REQ-005 SHALL have registered MEM/WB outputs: wb_mem_to_reg 2, wb_reg_write_en 1, wb_alu_result 32, wb_load_data 32, wb_rd_addr 5, mem_misalign 1.

Function
REQ-006 FSM states SHALL be IDLE and BUSY.
REQ-007 IDLE, no read/write enable: SHALL copy inputs to wb_* at next posedge; mem_stall=0; wb_load_data=0; 1-cycle latency.
REQ-008 IDLE with read or write enable (aligned): mem_stall=1 combinationally; SHALL latch addr/wdata/wstrb/we; SHALL go to BUSY; wb_reg_write_en=0 at next edge (bubble).
REQ-009 BUSY: dmem_req=1 with stable dmem_addr/we/wdata/wstrb until the cycle dmem_ack=1.
REQ-010 BUSY, dmem_ack=0: mem_stall=1; wb_reg_write_en=0 at next edge.
REQ-011 BUSY, dmem_ack=1: mem_stall=0 that cycle; next edge SHALL write wb_* from current inputs, wb_load_data from formatted dmem_rdata (0 for stores), and return to IDLE.
REQ-012 Minimum memory-op latency SHALL be 2 cycles; each ack-free cycle adds 1.
REQ-013 dmem_ack outside BUSY SHALL be ignored.
REQ-014 dmem_addr SHALL be {mem_alu_result[31:2],2'b00}.
REQ-015 Store strobes: funct3 000 -> 4'b0001<<addr[1:0]; 001 -> 4'b0011<<{addr[1],1'b0}; else 4'b1111.
REQ-016 Store data: SB byte replicated x4; SH halfword replicated x2; SW unchanged.
REQ-017 Loads: 000 LB sign-extend, 001 LH sign-extend, 100 LBU, 101 LHU zero-extend, selected by addr[1:0]; other funct3 values SHALL be treated as LW.
REQ-018 Read and write both set: write SHALL take precedence (dmem_we=1).

Reset
REQ-019 rst SHALL force IDLE, dmem_req=0, dmem_we=0, dmem_wstrb=0, mem_stall=0 and all wb_* outputs and mem_misalign to 0.
REQ-020 rst during BUSY SHALL abandon the access; a later dmem_ack SHALL be ignored.

Configuration
REQ-021 Macro MEM_MISALIGN_TRAP_EN defined: misaligned access (word addr[1:0]!=0, half addr[0]!=0) SHALL issue no bus request, no stall, wb_reg_write_en=0, mem_misalign=1 for one cycle at next edge.
REQ-022 Macro undefined: misalignment SHALL be ignored (access proceeds using aligned word and REQ-015/017 lane rules); mem_misalign tied 0.

Structure
REQ-023 funct3 size encodings, mem_to_reg encodings and FSM state encodings SHALL live in the shared constants header.
REQ-024 Load extraction/extension SHALL be a combinational sub-module load_formatter.

Verification
REQ-025 LW addr 0x100, ack 1st BUSY cycle, rdata 0xDEADBEEF -> stall 1 cycle, wb_load_data=0xDEADBEEF, wb_reg_write_en=1.
REQ-026 LB addr 0x103, rdata 0x80123456 -> wb_load_data=0xFFFFFF80; LBU -> 0x00000080.
REQ-027 SH addr 0x202, rs2 0x0000ABCD, ack after 3 cycles -> dmem_wstrb=4'b1100, dmem_wdata=0xABCDABCD held stable, stall 4 cycles.
REQ-028 ALU op (no mem) back-to-back x3 -> no stall, wb_* follows inputs 1 cycle later.
REQ-029 LW addr 0x102: with MEM_MISALIGN_TRAP_EN -> dmem_req=0, mem_misalign=1; without -> read 0x100, normal completion.
REQ-030 rst asserted in BUSY then late ack -> all outputs 0, IDLE, no wb write.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage_pkg
// Description : Shared constants for the memory-access pipeline stage:
//               funct3 access-size encodings, MEM/WB write-back source
//               select encodings, FSM state encoding and small helper
//               functions for store lane steering and alignment checks.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_stage_pkg;

  // funct3 access size / signedness (loads and stores share encodings)
  localparam logic [2:0] F3_BYTE   = 3'b000;  // LB / SB
  localparam logic [2:0] F3_HALF   = 3'b001;  // LH / SH
  localparam logic [2:0] F3_WORD   = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BYTE_U = 3'b100;  // LBU
  localparam logic [2:0] F3_HALF_U = 3'b101;  // LHU

  // funct3[1:0] size field
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  // mem_to_reg write-back source select
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Byte-lane write strobes for a store
  function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_BYTE: store_strobe = 4'b0001 << off;
      F3_HALF: store_strobe = 4'b0011 << {off[1], 1'b0};
      default: store_strobe = 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so the strobes alone pick the target
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      F3_BYTE: store_data = {4{d[7:0]}};
      F3_HALF: store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  // Byte accesses never misalign; halves need addr[0]==0; words need addr[1:0]==0
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      default: is_misaligned = |off;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_formatter.sv
`default_nettype none
// ============================================================================
// Module      : load_formatter
// Description : Combinational load data extraction and extension. Picks the
//               byte/halfword lane selected by the address offset and sign-
//               or zero-extends it; unknown funct3 values behave as LW.
// Ports       : rdata  in  32  raw word from data memory
//               offset in  2   address bits [1:0]
//               funct3 in  3   access size / signedness
//               data   out 32  formatted load value
// Revision    : 1.0 - initial release
// ============================================================================
module load_formatter
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_BYTE:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_HALF:   data = {{16{half_sel[15]}}, half_sel};
      F3_BYTE_U: data = {24'h0, byte_sel};
      F3_HALF_U: data = {16'h0, half_sel};
      default:   data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Pipeline MEM stage. Non-memory ops pass to MEM/WB in one
//               cycle. Loads/stores stall the pipe, issue a request on the
//               data-memory bus and hold it stable until dmem_ack, then
//               write MEM/WB with the formatted load data.
// Ports       : clk, rst (async, active-high)
//               mem_* in     EX/MEM register fields
//               dmem_* out/in data-memory request/response bus
//               mem_stall out hold upstream stages
//               wb_*, mem_misalign out registered MEM/WB fields
// Config      : MEM_MISALIGN_TRAP_EN - when defined, misaligned half/word
//               accesses are dropped and flagged on mem_misalign instead of
//               being performed on the aligned word.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mem_mem_to_reg,
  input  logic        mem_mem_read_en,
  input  logic        mem_mem_write_en,
  input  logic        mem_reg_write_en,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_rs2_data,
  input  logic [4:0]  mem_rd_addr,
  input  logic [2:0]  mem_funct3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [1:0]  wb_mem_to_reg,
  output logic        wb_reg_write_en,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_load_data,
  output logic [4:0]  wb_rd_addr,
  output logic        mem_misalign
);

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  offset_q, offset_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic        wb_reg_write_en_q, wb_reg_write_en_d;
  logic [31:0] wb_alu_result_q, wb_alu_result_d;
  logic [31:0] wb_load_data_q, wb_load_data_d;
  logic [4:0]  wb_rd_addr_q, wb_rd_addr_d;
  logic        misalign_q, misalign_d;

  logic        mem_op;
  logic        trap;
  logic        stall_c;
  logic [31:0] load_fmt;

  assign mem_op = mem_mem_read_en | mem_mem_write_en;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = mem_op & is_misaligned(mem_funct3[1:0], mem_alu_result[1:0]);
`else
  assign trap = 1'b0;
`endif

  // Offset/funct3 are captured at issue so formatting does not depend on
  // upstream keeping them stable.
  load_formatter u_load_formatter (
    .rdata  (dmem_rdata),
    .offset (offset_q),
    .funct3 (funct3_q),
    .data   (load_fmt)
  );

  always_comb begin
    state_d           = state_q;
    req_d             = req_q;
    we_d              = we_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    wstrb_d           = wstrb_q;
    offset_d          = offset_q;
    funct3_d          = funct3_q;
    wb_mem_to_reg_d   = wb_mem_to_reg_q;
    wb_reg_write_en_d = wb_reg_write_en_q;
    wb_alu_result_d   = wb_alu_result_q;
    wb_load_data_d    = wb_load_data_q;
    wb_rd_addr_d      = wb_rd_addr_q;
    misalign_d        = 1'b0;
    stall_c           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        wb_mem_to_reg_d   = mem_mem_to_reg;
        wb_reg_write_en_d = mem_reg_write_en;
        wb_alu_result_d   = mem_alu_result;
        wb_load_data_d    = 32'h0;
        wb_rd_addr_d      = mem_rd_addr;
        if (mem_op) begin
          // Either a bubble while the access runs, or a trapped access
          wb_reg_write_en_d = 1'b0;
          if (trap) begin
            misalign_d = 1'b1;
          end else begin
            stall_c  = 1'b1;
            state_d  = ST_BUSY;
            req_d    = 1'b1;
            we_d     = mem_mem_write_en;  // write wins when both are set
            addr_d   = {mem_alu_result[31:2], 2'b00};
            wdata_d  = store_data(mem_funct3, mem_rs2_data);
            wstrb_d  = mem_mem_write_en ? store_strobe(mem_funct3, mem_alu_result[1:0]) : 4'b0000;
            offset_d = mem_alu_result[1:0];
            funct3_d = mem_funct3;
          end
        end
      end
      ST_BUSY: begin
        if (dmem_ack) begin
          state_d           = ST_IDLE;
          req_d             = 1'b0;
          we_d              = 1'b0;
          wstrb_d           = 4'b0000;
          wb_mem_to_reg_d   = mem_mem_to_reg;
          wb_reg_write_en_d = mem_reg_write_en;
          wb_alu_result_d   = mem_alu_result;
          wb_load_data_d    = we_q ? 32'h0 : load_fmt;
          wb_rd_addr_d      = mem_rd_addr;
        end else begin
          stall_c           = 1'b1;
          wb_reg_write_en_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      req_q             <= 1'b0;
      we_q              <= 1'b0;
      addr_q            <= 32'h0;
      wdata_q           <= 32'h0;
      wstrb_q           <= 4'b0000;
      offset_q          <= 2'b00;
      funct3_q          <= 3'b000;
      wb_mem_to_reg_q   <= 2'b00;
      wb_reg_write_en_q <= 1'b0;
      wb_alu_result_q   <= 32'h0;
      wb_load_data_q    <= 32'h0;
      wb_rd_addr_q      <= 5'd0;
      misalign_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      req_q             <= req_d;
      we_q              <= we_d;
      addr_q            <= addr_d;
      wdata_q           <= wdata_d;
      wstrb_q           <= wstrb_d;
      offset_q          <= offset_d;
      funct3_q          <= funct3_d;
      wb_mem_to_reg_q   <= wb_mem_to_reg_d;
      wb_reg_write_en_q <= wb_reg_write_en_d;
      wb_alu_result_q   <= wb_alu_result_d;
      wb_load_data_q    <= wb_load_data_d;
      wb_rd_addr_q      <= wb_rd_addr_d;
      misalign_q        <= misalign_d;
    end
  end

  // Stall is combinational, so it is masked while reset is held
  assign mem_stall       = stall_c & ~rst;
  assign dmem_req        = req_q;
  assign dmem_we         = we_q;
  assign dmem_addr       = addr_q;
  assign dmem_wdata      = wdata_q;
  assign dmem_wstrb      = wstrb_q;
  assign wb_mem_to_reg   = wb_mem_to_reg_q;
  assign wb_reg_write_en = wb_reg_write_en_q;
  assign wb_alu_result   = wb_alu_result_q;
  assign wb_load_data    = wb_load_data_q;
  assign wb_rd_addr      = wb_rd_addr_q;
  assign mem_misalign    = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Directed self-checking bench for mem_access_stage. Expected
//               MEM/WB records are queued when an op is driven and compared
//               when the stage commits it. Honours MEM_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mem_mem_to_reg;
  logic        mem_mem_read_en, mem_mem_write_en, mem_reg_write_en;
  logic [31:0] mem_alu_result, mem_rs2_data;
  logic [4:0]  mem_rd_addr;
  logic [2:0]  mem_funct3;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        mem_stall;
  logic [1:0]  wb_mem_to_reg;
  logic        wb_reg_write_en;
  logic [31:0] wb_alu_result, wb_load_data;
  logic [4:0]  wb_rd_addr;
  logic        mem_misalign;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  m2r;
    logic        rwe;
    logic [31:0] alu;
    logic [31:0] load;
    logic [4:0]  rd;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_mem_read_en(mem_mem_read_en),
    .mem_mem_write_en(mem_mem_write_en), .mem_reg_write_en(mem_reg_write_en),
    .mem_alu_result(mem_alu_result), .mem_rs2_data(mem_rs2_data),
    .mem_rd_addr(mem_rd_addr), .mem_funct3(mem_funct3),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write_en(wb_reg_write_en),
    .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data),
    .wb_rd_addr(wb_rd_addr), .mem_misalign(mem_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference load formatting, written independently from the RTL
  function automatic logic [31:0] fmt_model(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[int'(off)*8 +: 8];
    h = d[(off[1] ? 16 : 0) +: 16];
    if (f3 == 3'b000)      return {{24{b[7]}}, b};
    else if (f3 == 3'b001) return {{16{h[15]}}, h};
    else if (f3 == 3'b100) return {24'h0, b};
    else if (f3 == 3'b101) return {16'h0, h};
    else                   return d;
  endfunction

  function automatic exp_t mk(input logic [1:0] m2r, input logic rwe, input logic [31:0] alu,
                              input logic [31:0] load, input logic [4:0] rd, input logic mis);
    exp_t e;
    e.m2r = m2r; e.rwe = rwe; e.alu = alu; e.load = load; e.rd = rd; e.mis = mis;
    return e;
  endfunction

  // Drive one EX/MEM op, respond on the bus, and compare the committed record.
  task automatic op(input logic rd_en, input logic wr_en, input logic [31:0] addr,
                    input logic [31:0] rs2, input logic [2:0] f3, input logic [1:0] m2r,
                    input logic rwe, input logic [4:0] rda, input int ack_wait,
                    input logic [31:0] rdata, input bit spur, input exp_t e,
                    input int e_stall, input logic [31:0] e_addr,
                    input logic [3:0] e_strb, input logic [31:0] e_wdata);
    int   busy, stalls, guard;
    bit   done;
    exp_t got;
    @(negedge clk);
    mem_mem_read_en = rd_en; mem_mem_write_en = wr_en; mem_alu_result = addr;
    mem_rs2_data = rs2; mem_funct3 = f3; mem_mem_to_reg = m2r;
    mem_reg_write_en = rwe; mem_rd_addr = rda;
    sb_q.push_back(e);
    busy = 0; stalls = 0; guard = 0; done = 0;
    while (!done && guard < 40) begin
      if (dmem_req) begin
        chk("bus_addr", dmem_addr, e_addr);
        chk("bus_we", dmem_we, wr_en);
        if (wr_en) begin
          chk("bus_wstrb", dmem_wstrb, e_strb);
          chk("bus_wdata", dmem_wdata, e_wdata);
        end
        if (busy == ack_wait) begin dmem_ack = 1'b1; dmem_rdata = rdata; end
        else begin dmem_ack = 1'b0; dmem_rdata = $urandom; end
        busy++;
      end else begin
        dmem_ack = spur; dmem_rdata = $urandom;
      end
      #1;
      if (mem_stall) stalls++; else done = 1;
      @(posedge clk); #1;
      if (!done) begin
        chk("bubble_rwe", wb_reg_write_en, 1'b0);
        @(negedge clk);
      end
      guard++;
    end
    got = sb_q.pop_front();
    if (!done) begin
      total++; bad++;
      $error("FAIL timeout observed=stalled expected=ack_complete");
    end else begin
      chk("wb_m2r", wb_mem_to_reg, got.m2r);
      chk("wb_rwe", wb_reg_write_en, got.rwe);
      chk("wb_alu", wb_alu_result, got.alu);
      chk("wb_load", wb_load_data, got.load);
      chk("wb_rd", wb_rd_addr, got.rd);
      chk("misalign", mem_misalign, got.mis);
      chk("stall_cycles", stalls, e_stall);
      chk("req_after", dmem_req, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] rd_v;
    logic [31:0] a;
    logic [2:0]  f3;
    logic [2:0]  f3_tab [5];
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b100; f3_tab[3] = 3'b101; f3_tab[4] = 3'b010;

    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    mem_mem_to_reg = 2'b11; mem_mem_read_en = 1'b1; mem_mem_write_en = 1'b0;
    mem_reg_write_en = 1'b1; mem_alu_result = 32'h1234_5678; mem_rs2_data = 32'h0;
    mem_rd_addr = 5'd7; mem_funct3 = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_stall", mem_stall, 1'b0);
    chk("rst_wstrb", dmem_wstrb, 4'h0);
    chk("rst_rwe", wb_reg_write_en, 1'b0);
    chk("rst_alu", wb_alu_result, 32'h0);
    mem_mem_read_en = 1'b0;
    @(negedge clk); rst = 1'b0;

    // Back-to-back ALU ops; the last one sees a spurious ack in IDLE
    op(0, 0, 32'h0000_0011, 32'h0, 3'b010, 2'b00, 1, 5'd1, 0, 32'h0, 0,
       mk(2'b00, 1, 32'h0000_0011, 32'h0, 5'd1, 0), 0, 32'h0, 4'h0, 32'h0);
    op(0, 0, 32'hFFFF_0022, 32'h0, 3'b010, 2'b10, 1, 5'd2, 0, 32'h0, 0,
       mk(2'b10, 1, 32'hFFFF_0022, 32'h0, 5'd2, 0), 0, 32'h0, 4'h0, 32'h0);
    op(0, 0, 32'h8000_0033, 32'h0, 3'b010, 2'b00, 0, 5'd3, 0, 32'h0, 1,
       mk(2'b00, 0, 32'h8000_0033, 32'h0, 5'd3, 0), 0, 32'h0, 4'h0, 32'h0);

    // LW, ack in first BUSY cycle
    op(1, 0, 32'h0000_0100, 32'h0, 3'b010, 2'b01, 1, 5'd5, 0, 32'hDEAD_BEEF, 0,
       mk(2'b01, 1, 32'h0000_0100, 32'hDEAD_BEEF, 5'd5, 0), 1, 32'h0000_0100, 4'h0, 32'h0);
    // LB / LBU at the top byte
    op(1, 0, 32'h0000_0103, 32'h0, 3'b000, 2'b01, 1, 5'd6, 0, 32'h8012_3456, 0,
       mk(2'b01, 1, 32'h0000_0103, 32'hFFFF_FF80, 5'd6, 0), 1, 32'h0000_0100, 4'h0, 32'h0);
    op(1, 0, 32'h0000_0103, 32'h0, 3'b100, 2'b01, 1, 5'd6, 1, 32'h8012_3456, 0,
       mk(2'b01, 1, 32'h0000_0103, 32'h0000_0080, 5'd6, 0), 2, 32'h0000_0100, 4'h0, 32'h0);
    // LH / LHU at upper half
    op(1, 0, 32'h0000_0106, 32'h0, 3'b001, 2'b01, 1, 5'd8, 0, 32'h8001_7FFF, 0,
       mk(2'b01, 1, 32'h0000_0106, 32'hFFFF_8001, 5'd8, 0), 1, 32'h0000_0104, 4'h0, 32'h0);
    op(1, 0, 32'h0000_0106, 32'h0, 3'b101, 2'b01, 1, 5'd8, 0, 32'h8001_7FFF, 0,
       mk(2'b01, 1, 32'h0000_0106, 32'h0000_8001, 5'd8, 0), 1, 32'h0000_0104, 4'h0, 32'h0);
    // SH with three ack-free BUSY cycles
    op(0, 1, 32'h0000_0202, 32'h0000_ABCD, 3'b001, 2'b00, 0, 5'd0, 3, 32'hFFFF_FFFF, 0,
       mk(2'b00, 0, 32'h0000_0202, 32'h0, 5'd0, 0), 4, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD);
    // SW
    op(0, 1, 32'h0000_0400, 32'h1234_5678, 3'b010, 2'b00, 0, 5'd0, 1, 32'h0, 0,
       mk(2'b00, 0, 32'h0000_0400, 32'h0, 5'd0, 0), 2, 32'h0000_0400, 4'b1111, 32'h1234_5678);
    // Read and write both set: write wins, no load data
    op(1, 1, 32'h0000_0404, 32'hCAFE_0001, 3'b010, 2'b00, 0, 5'd9, 0, 32'h5555_5555, 0,
       mk(2'b00, 0, 32'h0000_0404, 32'h0, 5'd9, 0), 1, 32'h0000_0404, 4'b1111, 32'hCAFE_0001);

    // Misaligned LW
`ifdef MEM_MISALIGN_TRAP_EN
    op(1, 0, 32'h0000_0102, 32'h0, 3'b010, 2'b01, 1, 5'd10, 0, 32'hCAFE_F00D, 0,
       mk(2'b01, 0, 32'h0000_0102, 32'h0, 5'd10, 1), 0, 32'h0000_0100, 4'h0, 32'h0);
`else
    op(1, 0, 32'h0000_0102, 32'h0, 3'b010, 2'b01, 1, 5'd10, 0, 32'hCAFE_F00D, 0,
       mk(2'b01, 1, 32'h0000_0102, 32'hCAFE_F00D, 5'd10, 0), 1, 32'h0000_0100, 4'h0, 32'h0);
`endif

    // Aligned loads of mixed sizes with random data
    for (int i = 0; i < 6; i++) begin
      f3   = f3_tab[$urandom_range(0, 4)];
      a    = 32'h0000_1000 + {$urandom_range(0, 15), 2'b00};
      if (f3[1:0] == 2'b00)      a[1:0] = 2'($urandom_range(0, 3));
      else if (f3[1:0] == 2'b01) a[1]   = 1'($urandom_range(0, 1));
      rd_v = $urandom;
      op(1, 0, a, 32'h0, f3, 2'b01, 1, 5'd11, i % 3, rd_v, 0,
         mk(2'b01, 1, a, fmt_model(f3, a[1:0], rd_v), 5'd11, 0), 1 + i % 3,
         {a[31:2], 2'b00}, 4'h0, 32'h0);
    end

    // SB at every lane
    for (int k = 0; k < 4; k++) begin
      a    = 32'h0000_2000 + 32'(k);
      rd_v = $urandom;
      op(0, 1, a, rd_v, 3'b000, 2'b00, 0, 5'd0, 0, 32'h0, 0,
         mk(2'b00, 0, a, 32'h0, 5'd0, 0), 1, 32'h0000_2000,
         4'(4'b0001 << k), {4{rd_v[7:0]}});
    end

    chk("queue_empty", sb_q.size(), 0);

    // Reset in BUSY, then a late ack that must be ignored
    @(negedge clk);
    mem_mem_read_en = 1'b1; mem_mem_write_en = 1'b0; mem_alu_result = 32'h0000_0300;
    mem_funct3 = 3'b010; mem_reg_write_en = 1'b1; mem_rd_addr = 5'd12; dmem_ack = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_req", dmem_req, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("rst_busy_req", dmem_req, 1'b0);
    chk("rst_busy_we", dmem_we, 1'b0);
    chk("rst_busy_wstrb", dmem_wstrb, 4'h0);
    chk("rst_busy_stall", mem_stall, 1'b0);
    chk("rst_busy_rwe", wb_reg_write_en, 1'b0);
    chk("rst_busy_mis", mem_misalign, 1'b0);
    mem_mem_read_en = 1'b0; mem_reg_write_en = 1'b0; mem_alu_result = 32'h0000_0055;
    @(negedge clk);
    rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      chk("late_ack_req", dmem_req, 1'b0);
      chk("late_ack_stall", mem_stall, 1'b0);
      chk("late_ack_rwe", wb_reg_write_en, 1'b0);
      chk("late_ack_load", wb_load_data, 32'h0);
      chk("late_ack_alu", wb_alu_result, 32'h0000_0055);
    end
    dmem_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
